// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: programmable clock divider with glitch-free start/stop and a
// valid/ready divisor configuration port.
//
// Optional feature: define CLK_DIV_CTRL_TICK_CNT_EN to add the 32-bit tick_cnt
// output, which counts clk_out rising edges.
//
// Handshake: a divisor transfers on a rising edge where cfg_valid && cfg_ready.
// cfg_ready is simply !pending, so at most one divisor waits for a toggle edge.
// The offering side must hold cfg_valid/cfg_div stable until the transfer edge.
module clk_div_ctrl #(
   parameter int DIV_WIDTH   = 16,
   parameter int DEFAULT_DIV = 25
) (
   input  logic                 clk_in,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 cfg_valid,
   input  logic [DIV_WIDTH-1:0] cfg_div,
   output logic                 cfg_ready,
   output logic                 cfg_err,
   output logic                 clk_out,
   output logic                 tick,
   output logic                 busy,
   output logic                 pending,
   output logic [1:0]           fsm_state
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
   ,
   output logic [31:0]          tick_cnt
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t               state;
   state_t               state_next;
   logic [DIV_WIDTH-1:0] timer;
   logic [DIV_WIDTH-1:0] div_act;
   logic [DIV_WIDTH-1:0] div_pend;
   logic                 at_end;
   logic                 abort;
   logic                 do_toggle;
   logic                 xfer;
   logic                 leaving;
   logic                 apply;

   // Toggle and handshake qualifiers; stopping while low beats a coincident toggle.
   always_comb begin
      at_end    = (timer == (div_act - DIV_WIDTH'(1)));
      abort     = (state == RUN) && stop && !clk_out;
      do_toggle = (state != IDLE) && !abort && at_end;
      xfer      = cfg_valid && !pending;
   end

   // State register.
   always_ff @(posedge clk_in) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state logic; a stop with clk_out high waits for the falling toggle.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (start && !stop) state_next = RUN;
         end
         RUN: begin
            if (stop) begin
               if (!clk_out || do_toggle) state_next = IDLE;
               else                       state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (start && !stop) state_next = RUN;
            else if (do_toggle) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // FSM-derived outputs.
   always_comb begin
      busy      = (state != IDLE);
      fsm_state = state;
      cfg_ready = !pending;
      leaving   = (state != IDLE) && (state_next == IDLE);
      apply     = pending && ((state == IDLE) || do_toggle || leaving);
   end

   // Half-period timer, divided clock and tick pulse.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         timer   <= '0;
         clk_out <= 1'b0;
         tick    <= 1'b0;
      end else if ((state == IDLE) || abort) begin
         timer   <= '0;
         clk_out <= 1'b0;
         tick    <= 1'b0;
      end else if (do_toggle) begin
         timer   <= '0;
         clk_out <= ~clk_out;
         tick    <= 1'b1;
      end else begin
         timer   <= timer + DIV_WIDTH'(1);
         tick    <= 1'b0;
      end
   end

   // Divisor bookkeeping: direct load while idle, otherwise park until a toggle.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         div_act  <= DIV_WIDTH'(DEFAULT_DIV);
         div_pend <= '0;
         pending  <= 1'b0;
         cfg_err  <= 1'b0;
      end else begin
         cfg_err <= xfer && (cfg_div == '0);
         if (apply) begin
            div_act <= div_pend;
            pending <= 1'b0;
         end else if (xfer && (cfg_div != '0)) begin
            if (state == IDLE) begin
               div_act <= cfg_div;
            end else begin
               div_pend <= cfg_div;
               pending  <= 1'b1;
            end
         end
      end
   end

`ifdef CLK_DIV_CTRL_TICK_CNT_EN
   // Rising-edge counter; wraps naturally at 32 bits.
   always_ff @(posedge clk_in) begin
      if (rst)                       tick_cnt <= '0;
      else if (do_toggle && !clk_out) tick_cnt <= tick_cnt + 32'd1;
   end
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed and randomized bench for clk_div_ctrl with a
// countdown-based reference model of the divider.
module tb_clk_div_ctrl;

   logic        clk_in = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        cfg_valid = 1'b0;
   logic [15:0] cfg_div = 16'd0;
   logic        cfg_ready;
   logic        cfg_err;
   logic        clk_out;
   logic        tick;
   logic        busy;
   logic        pending;
   logic [1:0]  fsm_state;
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
   logic [31:0] tick_cnt;
`endif

   int checks = 0;
   int errors = 0;

   // reference model: mode 0 idle, 1 run, 2 drain; left = edges until next toggle
   int          m_mode = 0;
   int          m_left = 0;
   int          m_div = 25;
   int          m_dpend = 0;
   bit          m_pend = 0;
   bit          m_clk = 0;
   bit          m_tick = 0;
   bit          m_err = 0;
   logic [31:0] m_cnt = 32'd0;

   // clock / reset
   always #5 clk_in = ~clk_in;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   clk_div_ctrl #(.DIV_WIDTH(16), .DEFAULT_DIV(25)) dut (
      .clk_in    (clk_in),
      .rst       (rst),
      .start     (start),
      .stop      (stop),
      .cfg_valid (cfg_valid),
      .cfg_div   (cfg_div),
      .cfg_ready (cfg_ready),
      .cfg_err   (cfg_err),
      .clk_out   (clk_out),
      .tick      (tick),
      .busy      (busy),
      .pending   (pending),
      .fsm_state (fsm_state)
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
      ,
      .tick_cnt  (tick_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      bit xfer;
      bit good;
      bit tog;
      int nmode;
      if (rst) begin
         m_mode = 0; m_left = 0; m_div = 25; m_dpend = 0; m_pend = 0;
         m_clk = 0; m_tick = 0; m_err = 0; m_cnt = 32'd0;
      end else begin
         xfer   = cfg_valid && !m_pend;
         good   = xfer && (cfg_div != 16'd0);
         m_err  = xfer && (cfg_div == 16'd0);
         m_tick = 0;
         if (m_mode == 0) begin
            if (m_pend) begin
               m_div = m_dpend; m_pend = 0;
            end else if (good) begin
               m_div = int'(cfg_div);
            end
            if (start && !stop) begin
               m_mode = 1; m_left = m_div;
            end
         end else if (m_mode == 1 && stop && !m_clk) begin
            m_mode = 0;
            if (m_pend) begin
               m_div = m_dpend; m_pend = 0;
            end
            if (good) begin
               m_dpend = int'(cfg_div); m_pend = 1;
            end
         end else begin
            m_left = m_left - 1;
            tog = (m_left == 0);
            nmode = m_mode;
            if (m_mode == 1) begin
               if (stop) nmode = tog ? 0 : 2;
            end else begin
               if (start && !stop) nmode = 1;
               else if (tog)       nmode = 0;
            end
            if (tog) begin
               if (!m_clk) m_cnt = m_cnt + 32'd1;
               m_clk = !m_clk;
               m_tick = 1;
               if (m_pend) begin
                  m_div = m_dpend; m_pend = 0;
               end
               m_left = m_div;
            end
            m_mode = nmode;
            if (good) begin
               m_dpend = int'(cfg_div); m_pend = 1;
            end
         end
      end
   endtask

   task automatic check_all();
      chk("clk_out", 32'(clk_out), 32'(m_clk));
      chk("tick", 32'(tick), 32'(m_tick));
      chk("busy", 32'(busy), 32'(m_mode != 0));
      chk("pending", 32'(pending), 32'(m_pend));
      chk("cfg_ready", 32'(cfg_ready), 32'(!m_pend));
      chk("cfg_err", 32'(cfg_err), 32'(m_err));
      chk("fsm_state_busy", 32'(fsm_state != 2'd0), 32'(m_mode != 0));
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
      chk("tick_cnt", tick_cnt, m_cnt);
`endif
   endtask

   // driver: apply inputs, take one edge, advance model, compare
   task automatic cycle(input logic st, input logic sp, input logic cv, input logic [15:0] cd);
      start = st; stop = sp; cfg_valid = cv; cfg_div = cd;
      @(posedge clk_in);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle(1'b0, 1'b0, 1'b0, 16'd0);
      rst = 1'b0;
   endtask

   task automatic run_until_clk(input logic lvl, input int max, input logic st, input logic sp,
                                output int n);
      n = 0;
      while (clk_out !== lvl && n < max) begin
         cycle(st, sp, 1'b0, 16'd0);
         n++;
      end
      chk("wait_clk_level", 32'(clk_out), 32'(lvl));
   endtask

   task automatic stop_to_idle();
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 200) begin
         cycle(1'b0, 1'b1, 1'b0, 16'd0);
         n++;
      end
      chk("stop_to_idle", 32'(busy), 32'd0);
   endtask

   initial begin
      int n;
      int n1;
      int n2;
      int ticks;
      logic st;
      logic sp;
      logic cv;
      logic [15:0] cd;

      // reset state
      do_reset();
      cycle(1'b0, 1'b0, 1'b0, 16'd0);
      chk("rst_clk_out", 32'(clk_out), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);

      // default divider: rise 25 edges after start, fall 25 later
      cycle(1'b1, 1'b0, 1'b0, 16'd0);
      chk("busy_after_start", 32'(busy), 32'd1);
      run_until_clk(1'b1, 100, 1'b0, 1'b0, n);
      chk("first_rise_edge", 32'(n), 32'd25);
      run_until_clk(1'b0, 100, 1'b0, 1'b0, n);
      chk("first_fall_gap", 32'(n), 32'd25);
      cycle(1'b0, 1'b1, 1'b0, 16'd0);
      chk("stop_low_idle", 32'(busy), 32'd0);
      chk("stop_low_no_tick", 32'(tick), 32'd0);

      // divisor 3 loaded while idle
      cycle(1'b0, 1'b0, 1'b1, 16'd3);
      chk("idle_cfg_ready", 32'(cfg_ready), 32'd1);
      chk("idle_cfg_pending", 32'(pending), 32'd0);
      cycle(1'b1, 1'b0, 1'b0, 16'd0);
      ticks = 0;
      for (int i = 0; i < 12; i++) begin
         cycle(1'b0, 1'b0, 1'b0, 16'd0);
         if (tick === 1'b1) ticks++;
      end
      chk("div3_ticks_12", 32'(ticks), 32'd4);
      run_until_clk(1'b1, 20, 1'b0, 1'b0, n);
      run_until_clk(1'b0, 20, 1'b0, 1'b0, n1);
      run_until_clk(1'b1, 20, 1'b0, 1'b0, n2);
      chk("div3_period", 32'(n1 + n2), 32'd6);
      stop_to_idle();

      // reconfigure while running: 4 -> 2 mid high phase, second offer stalls
      cycle(1'b0, 1'b0, 1'b1, 16'd4);
      cycle(1'b1, 1'b0, 1'b0, 16'd0);
      run_until_clk(1'b1, 20, 1'b0, 1'b0, n);
      chk("div4_rise", 32'(n), 32'd4);
      cycle(1'b0, 1'b0, 1'b1, 16'd2);
      chk("run_cfg_pending", 32'(pending), 32'd1);
      chk("run_cfg_ready", 32'(cfg_ready), 32'd0);
      cycle(1'b0, 1'b0, 1'b1, 16'd7);
      chk("stall_pending", 32'(pending), 32'd1);
      run_until_clk(1'b0, 20, 1'b0, 1'b0, n);
      chk("apply_remaining_gap", 32'(n), 32'd2);
      chk("apply_cleared", 32'(pending), 32'd0);
      run_until_clk(1'b1, 20, 1'b0, 1'b0, n);
      chk("new_half_period", 32'(n), 32'd2);
      stop_to_idle();

      // glitch-free stop with divisor 5
      cycle(1'b0, 1'b0, 1'b1, 16'd5);
      cycle(1'b1, 1'b0, 1'b0, 16'd0);
      run_until_clk(1'b1, 20, 1'b0, 1'b0, n);
      chk("div5_rise", 32'(n), 32'd5);
      cycle(1'b0, 1'b1, 1'b0, 16'd0);
      chk("drain_busy", 32'(busy), 32'd1);
      chk("drain_clk_high", 32'(clk_out), 32'd1);
      run_until_clk(1'b0, 20, 1'b0, 1'b1, n);
      chk("drain_fall_gap", 32'(n), 32'd4);
      chk("drain_idle", 32'(busy), 32'd0);
      chk("drain_fall_tick", 32'(tick), 32'd1);
      cycle(1'b1, 1'b0, 1'b0, 16'd0);
      cycle(1'b0, 1'b0, 1'b0, 16'd0);
      cycle(1'b0, 1'b0, 1'b0, 16'd0);
      cycle(1'b0, 1'b1, 1'b0, 16'd0);
      chk("low_stop_idle", 32'(busy), 32'd0);
      chk("low_stop_tick", 32'(tick), 32'd0);

      // zero divisor rejected, reset mid high phase discards pending divisor
      cycle(1'b0, 1'b0, 1'b1, 16'd0);
      chk("zero_cfg_err", 32'(cfg_err), 32'd1);
      cycle(1'b0, 1'b0, 1'b0, 16'd0);
      chk("zero_cfg_err_clear", 32'(cfg_err), 32'd0);
      cycle(1'b1, 1'b0, 1'b0, 16'd0);
      run_until_clk(1'b1, 20, 1'b0, 1'b0, n);
      chk("div_kept_after_zero", 32'(n), 32'd5);
      cycle(1'b0, 1'b0, 1'b1, 16'd9);
      chk("pending_before_rst", 32'(pending), 32'd1);
      do_reset();
      chk("rst_mid_clk", 32'(clk_out), 32'd0);
      chk("rst_mid_pending", 32'(pending), 32'd0);
      cycle(1'b1, 1'b0, 1'b0, 16'd0);
      run_until_clk(1'b1, 100, 1'b0, 1'b0, n);
      chk("default_after_rst", 32'(n), 32'd25);

      // divisor 1 toggles every cycle
      do_reset();
      cycle(1'b0, 1'b0, 1'b1, 16'd1);
      cycle(1'b1, 1'b0, 1'b0, 16'd0);
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, 1'b0, 1'b0, 16'd0);
         chk("div1_tick", 32'(tick), 32'd1);
      end
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
      chk("div1_tick_cnt", tick_cnt, 32'd5);
`endif
      stop_to_idle();

`ifdef CLK_DIV_CTRL_TICK_CNT_EN
      // counter wrap
      force dut.tick_cnt = 32'hFFFF_FFFE;
      #1;
      release dut.tick_cnt;
      m_cnt = 32'hFFFF_FFFE;
      cycle(1'b1, 1'b0, 1'b0, 16'd0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 16'd0);
      chk("tick_cnt_wrap", tick_cnt, 32'd0);
      stop_to_idle();
`endif

      // randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         rst = ($urandom_range(0, 199) == 0);
         st  = ($urandom_range(0, 7) == 0);
         sp  = ($urandom_range(0, 19) == 0);
         cv  = ($urandom_range(0, 5) == 0);
         cd  = 16'($urandom_range(0, 6));
         cycle(st, sp, cv, cd);
      end
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 16, width of divisor and timer.
REQ-002 SHALL have parameter DEFAULT_DIV, default 25, half-period in clk_in cycles after reset (50 MHz in, 1 MHz out).
REQ-003 SHALL have clk_in  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have start  input  1  level, request run.
REQ-006 SHALL have stop  input  1  level, request glitch-free stop.
REQ-007 SHALL have cfg_valid  input  1  new divisor offered.
REQ-008 SHALL have cfg_div  input  DIV_WIDTH  offered half-period in cycles.
REQ-009 SHALL have cfg_ready  output  1  controller can accept a divisor.
REQ-010 SHALL have cfg_err  output  1  one-cycle pulse, offered divisor rejected.
REQ-011 SHALL have clk_out  output  1  registered divided clock.
REQ-012 SHALL have tick  output  1  one-cycle pulse in each cycle clk_out changes value.
REQ-013 SHALL have busy  output  1  high when state is not IDLE.
REQ-014 SHALL have pending  output  1  accepted divisor awaiting application.

Function
REQ-015 SHALL implement states IDLE, RUN, DRAIN; holds active divisor div_act, pending divisor div_pend, timer.
REQ-016 IDLE: timer held 0, clk_out held 0, tick 0; start=1 and stop=0 -> RUN; otherwise stay (stop wins when both high).
REQ-017 RUN: timer increments each cycle; at edge where timer==div_act-1, timer<=0, clk_out toggles, tick<=1.
REQ-018 First clk_out rise SHALL occur exactly div_act edges after the edge that samples start; period 2*div_act cycles, 50% duty.
REQ-019 RUN, stop=1, clk_out=0 -> IDLE next edge, timer cleared (low phase truncated, no runt high pulse).
REQ-020 RUN, stop=1, clk_out=1 -> DRAIN; DRAIN counts as RUN; at falling-edge toggle -> IDLE; start=1 in DRAIN returns to RUN without disturbing timer.
REQ-021 start in RUN and stop in IDLE SHALL be ignored.
REQ-022 Config handshake: transfer when cfg_valid && cfg_ready; cfg_ready = !pending.
REQ-023 Transfer with cfg_div==0 SHALL be rejected: cfg_err pulses next cycle, no state change.
REQ-024 Transfer in IDLE SHALL load div_act at that edge; pending stays 0.
REQ-025 Transfer in RUN/DRAIN SHALL load div_pend, set pending; applied (div_act<=div_pend, pending<=0) at the next toggle edge, new half-period starting from that edge.
REQ-026 Transfer in the same cycle as a toggle SHALL be applied at the following toggle, not the current one.
REQ-027 On RUN/DRAIN -> IDLE with pending=1, div_pend SHALL be applied on that transition edge.
REQ-028 Timer comparisons SHALL be unsigned at DIV_WIDTH; cfg_div=1 yields toggling every cycle; max 2^DIV_WIDTH-1 supported without overflow.

Reset
REQ-029 rst=1 at an edge SHALL force IDLE, timer=0, div_act=DEFAULT_DIV, div_pend=0, pending=0, clk_out=0, tick=0, cfg_err=0, cfg_ready=1, busy=0.
REQ-030 Reset mid-period SHALL drop clk_out to 0 at that edge and discard any pending divisor; rst overrides all inputs.

Configuration
REQ-031 Macro CLK_DIV_CTRL_TICK_CNT_EN defined: output tick_cnt (32 bits) counts clk_out rising edges, wraps 2^32-1 -> 0, cleared by rst, holds in IDLE.
REQ-032 Macro undefined: tick_cnt port and counter logic SHALL be absent; all other behaviour identical.

Verification
REQ-033 Reset, start=1 at edge 0 -> clk_out rises edge 25, falls edge 50, tick pulses those cycles, busy=1 from edge 1.
REQ-034 IDLE, offer cfg_div=3 -> cfg_ready stays 1, pending 0; start -> clk_out period 6 cycles.
REQ-035 RUN div=4, offer cfg_div=2 mid-high-phase -> pending=1, cfg_ready=0, second offer stalls; next toggle after 4 cycles, then toggles every 2.
REQ-036 RUN div=5, stop while clk_out=1 -> DRAIN, falls on scheduled edge, IDLE; stop while clk_out=0 -> IDLE next edge, no extra tick.
REQ-037 Offer cfg_div=0 -> cfg_err one cycle, div_act unchanged; assert rst mid-high with pending=1 -> clk_out=0, pending=0, div_act=25.
REQ-038 With CLK_DIV_CTRL_TICK_CNT_EN, div=1 run 10 cycles -> tick_cnt=5; preload near 2^32-1 via force -> wraps to 0.
